// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and memory handshakes.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             alu_src,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Bit positions within the one-hot class vector
    localparam int C_R    = 0;
    localparam int C_I    = 1;
    localparam int C_LD   = 2;
    localparam int C_ST   = 3;
    localparam int C_BR   = 4;
    localparam int C_JAL  = 5;
    localparam int C_JALR = 6;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] PC_P4   = 2'b00;
    localparam logic [1:0] PC_IMM  = 2'b01;
    localparam logic [1:0] PC_JALR = 2'b10;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [6:0]       r_class;
    logic [6:0]       w_dec_class;
    logic             w_dec_legal;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;

    always_comb begin
        w_dec_class = 7'b0;
        case (opcode)
            OP_R:    w_dec_class[C_R]    = 1'b1;
            OP_I:    w_dec_class[C_I]    = 1'b1;
            OP_LD:   w_dec_class[C_LD]   = 1'b1;
            OP_ST:   w_dec_class[C_ST]   = 1'b1;
            OP_BR:   w_dec_class[C_BR]   = 1'b1;
            OP_JAL:  w_dec_class[C_JAL]  = 1'b1;
            OP_JALR: w_dec_class[C_JALR] = 1'b1;
            default: w_dec_class = 7'b0;
        endcase
    end

    assign w_dec_legal = |w_dec_class;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  w_next = imem_ready ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_dec_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (r_class[C_BR])
                    w_next = S_FETCH;
                else if (r_class[C_LD] || r_class[C_ST])
                    w_next = S_MEM;
                else
                    w_next = S_WB;
            end
            S_MEM: begin
                if (dmem_ready)
                    w_next = r_class[C_ST] ? S_FETCH : S_WB;
                else
                    w_next = S_MEM;
            end
            S_WB:     w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs decode from the reset-cleared state, so they drop with rst_n
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = WB_ALU;
        alu_src  = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_P4;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            S_EXEC: begin
                alu_src = !(r_class[C_R] || r_class[C_BR]);
                if (r_class[C_BR]) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? PC_IMM : PC_P4;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = r_class[C_ST];
                alu_src  = 1'b1;
                pc_we    = r_class[C_ST] && dmem_ready;
            end
            S_WB: begin
                rf_we = 1'b1;
                pc_we = 1'b1;
                if (r_class[C_LD])
                    wb_sel = WB_MEM;
                else if (r_class[C_JAL] || r_class[C_JALR])
                    wb_sel = WB_PC4;
                if (r_class[C_JAL])
                    pc_sel = PC_IMM;
                else if (r_class[C_JALR])
                    pc_sel = PC_JALR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_class   <= 7'b0;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_class <= w_dec_class;
                if (!w_dec_legal)
                    r_illegal <= 1'b1;
            end
            if (pc_we)
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign state   = r_state;
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the RV32I core: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the PC, instruction-register, register-file and data-memory enables and muxes.
- Performs req/ready handshakes with the instruction and data memories.
- Decodes the 7-bit opcode internally into seven classes, flags illegal opcodes, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from the instruction register; valid from DECODE onward
- branch_taken  in  1  branch comparator result; sampled in EXEC
- imem_ready  in  1  instruction memory has data this cycle
- dmem_ready  in  1  data memory access completes this cycle
- imem_req  out  1  instruction fetch request
- ir_we  out  1  load the instruction register
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- rf_we  out  1  register file write enable
- wb_sel  out  2  writeback source: 00 ALU, 01 memory, 10 PC+4
- alu_src  out  1  ALU operand B: 0 rs2, 1 immediate
- pc_we  out  1  PC update enable
- pc_sel  out  2  next PC: 00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
- illegal  out  1  sticky illegal-opcode flag
- state  out  3  current state, for debug
- retired  out  CNT_W  count of retired instructions

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, class register cleared, illegal=0, retired=0.
  - All outputs 0.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
  - Encoding 7 is unreachable; if ever entered, next state is IDLE.
- IDLE: all outputs 0; unconditionally moves to FETCH on the next clock.
- FETCH:
  - imem_req=1 for every cycle in FETCH.
  - ir_we = imem_ready (Mealy) in the same cycle.
  - imem_ready=1 -> DECODE; otherwise stay in FETCH.
- DECODE: register the one-hot class from opcode.
  - 0110011 R
  - 0010011 I
  - 0000011 load
  - 0100011 store
  - 1100011 branch
  - 1101111 jal
  - 1100111 jalr
  - Any other opcode -> TRAP and set illegal=1. Otherwise -> EXEC.
- EXEC:
  - alu_src=0 for R and branch; 1 for all other classes.
  - R, I, jal, jalr -> WB. Load, store -> MEM.
  - Branch: pc_we=1, pc_sel = branch_taken ? 01 : 00, retire, -> FETCH.
- MEM:
  - dmem_req=1 held every cycle until dmem_ready. dmem_we=1 throughout for store, 0 for load.
  - alu_src=1 held so the address stays stable.
  - Store with dmem_ready=1: pc_we=1, pc_sel=00, retire, -> FETCH.
  - Load with dmem_ready=1: -> WB.
  - dmem_ready=0: stay in MEM.
- WB (one cycle): rf_we=1, pc_we=1, retire, -> FETCH.
  - wb_sel: 00 for R/I, 01 for load, 10 for jal/jalr.
  - pc_sel: 01 for jal, 10 for jalr, else 00.
- TRAP: all enables 0; stays in TRAP until reset. illegal stays 1.
- Retire: retired increments by 1 in every cycle where pc_we=1; wraps modulo 2^CNT_W.
- Handshake rules:
  - imem_ready is ignored outside FETCH; dmem_ready is ignored outside MEM.
  - A req, once raised, stays high until its ready is seen.
- Latency with zero-wait memories: branch 3 cycles; R, I, jal, jalr, store 4; load 5. Each wait cycle adds 1.
- Reset mid-operation: all outputs drop to 0 immediately, including any in-flight req/we. The sequence restarts through IDLE.

Test Plan:
- Reset, then opcode=0110011, imem_ready and dmem_ready tied 1:
  - State trace 0,1,2,3,5,1.
  - rf_we=1 and wb_sel=00 only in WB.
  - retired=1 after 5 clocks.
- Load (0000011) with dmem_ready held low 3 cycles in MEM:
  - dmem_req=1 and dmem_we=0 for 4 cycles.
  - Then WB with wb_sel=01; total 8 cycles FETCH->FETCH.
- Store (0100011), imem_ready delayed 2 cycles:
  - imem_req=1 for 3 cycles; ir_we pulses only in the third.
  - dmem_we=1 in MEM; rf_we never asserted.
  - pc_we with pc_sel=00.
- Branch (1100011), branch_taken=1 then 0 on two instructions:
  - EXEC shows pc_we=1 with pc_sel=01, then 00.
  - No rf_we; retired=2.
- jal then jalr:
  - WB shows wb_sel=10 with pc_sel=01, then wb_sel=10 with pc_sel=10.
- Opcode 0000000:
  - DECODE -> TRAP (state=6), illegal=1 held for 20 cycles, all enables 0.
  - Async rst_n pulse mid-cycle clears illegal and state immediately.
  - Separately: pull rst_n low during MEM with dmem_req=1; dmem_req must drop without waiting for a clock edge.
